// File: rtl/cpu_pkg.sv
// Shared constants, opcodes and enums for the 8-bit accumulator CPU.
// Imported by the memory interface, the ALU and the core.
package cpu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OPND_W = 16;
    localparam int unsigned PROD_W = 2 * DATA_W;

    localparam logic [DATA_W-1:0] OP_NOP = 8'h00;
    localparam logic [DATA_W-1:0] OP_LDI = 8'h01;
    localparam logic [DATA_W-1:0] OP_LDA = 8'h02;
    localparam logic [DATA_W-1:0] OP_STA = 8'h03;
    localparam logic [DATA_W-1:0] OP_ADD = 8'h04;
    localparam logic [DATA_W-1:0] OP_SUB = 8'h05;
    localparam logic [DATA_W-1:0] OP_MUL = 8'h06;
    localparam logic [DATA_W-1:0] OP_JMP = 8'h07;
    localparam logic [DATA_W-1:0] OP_JZ  = 8'h08;
    localparam logic [DATA_W-1:0] OP_JNZ = 8'h09;
    localparam logic [DATA_W-1:0] OP_DEC = 8'h0A;
    localparam logic [DATA_W-1:0] OP_HLT = 8'hFF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_OPLO,
        S_OPHI,
        S_EXEC,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_PASS,
        ALU_ADD,
        ALU_SUB,
        ALU_MUL,
        ALU_DEC
    } alu_op_e;

    // Opcodes 01..09 carry at least one operand byte after the opcode.
    function automatic logic has_operand(input logic [DATA_W-1:0] op);
        return (op >= OP_LDI) && (op <= OP_JNZ);
    endfunction

endpackage

// File: rtl/cpu_if.sv
// Byte-wide memory port between the core (master) and an external memory (slave).
// Read data is a combinational function of mem_addr; writes commit on the rising edge.
interface cpu_if
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata
    );

endinterface

// File: rtl/cpu_alu.sv
// Combinational ALU: PASS/ADD/SUB/MUL/DEC on the accumulator and a memory byte.
// Zero and carry/borrow are produced for every op; the core decides which to keep.
module cpu_alu
    import cpu_pkg::*;
(
    input  alu_op_e           i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_res_c,
    output logic              o_zero_c,
    output logic              o_carry_c
);

    logic [DATA_W:0]   w_sum;
    logic [PROD_W-1:0] w_prod;

    always_comb begin
        o_res_c   = i_b;
        o_carry_c = 1'b0;
        w_sum     = '0;
        w_prod    = '0;
        case (i_op)
            ALU_ADD: begin
                w_sum     = {1'b0, i_a} + {1'b0, i_b};
                o_res_c   = w_sum[DATA_W-1:0];
                o_carry_c = w_sum[DATA_W];
            end
            ALU_SUB: begin
                o_res_c   = i_a - i_b;
                o_carry_c = (i_a < i_b);
            end
            ALU_MUL: begin
                // Carry flags any information lost in the high product byte.
                w_prod    = PROD_W'(i_a) * PROD_W'(i_b);
                o_res_c   = w_prod[DATA_W-1:0];
                o_carry_c = |w_prod[PROD_W-1:DATA_W];
            end
            ALU_DEC: begin
                o_res_c   = i_a - DATA_W'(1);
                o_carry_c = (i_a == '0);
            end
            default: ;
        endcase
        o_zero_c = (o_res_c == '0);
    end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle 8-bit accumulator CPU: FETCH/OPLO/OPHI/EXEC/HALT, one memory access per cycle.
// The memory address is registered one state ahead so it always matches the current state.
module cpu_core
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(16'h0000)
) (
    input  logic              clk,
    input  logic              rst,
    cpu_if.master             mem,
    output logic              halted,
    output logic [DATA_W-1:0] acc_out,
    output logic [ADDR_W-1:0] pc_out
);

    state_e            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_acc;
    logic              r_z;
    logic              r_c;
    logic [DATA_W-1:0] r_opcode;
    logic [DATA_W-1:0] r_oplo;
    logic [ADDR_W-1:0] r_operand;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;
    logic              r_halted;

    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_operand;
    alu_op_e           w_alu_op;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_z;
    logic              w_alu_c;

    assign w_pc_inc  = r_pc + ADDR_W'(1);
    assign w_operand = ADDR_W'({mem.mem_rdata, r_oplo});

    // ALU op follows the opcode only in EXEC; LDI in OPLO uses the PASS default.
    always_comb begin
        w_alu_op = ALU_PASS;
        if (r_state == S_EXEC) begin
            case (r_opcode)
                OP_ADD:  w_alu_op = ALU_ADD;
                OP_SUB:  w_alu_op = ALU_SUB;
                OP_MUL:  w_alu_op = ALU_MUL;
                OP_DEC:  w_alu_op = ALU_DEC;
                default: w_alu_op = ALU_PASS;
            endcase
        end
    end

    cpu_alu u_alu (
        .i_op      (w_alu_op),
        .i_a       (r_acc),
        .i_b       (mem.mem_rdata),
        .o_res_c   (w_alu_res),
        .o_zero_c  (w_alu_z),
        .o_carry_c (w_alu_c)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_acc       <= '0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_opcode    <= OP_NOP;
            r_oplo      <= '0;
            r_operand   <= '0;
            r_mem_addr  <= RESET_PC;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    r_opcode   <= mem.mem_rdata;
                    r_pc       <= w_pc_inc;
                    r_mem_addr <= w_pc_inc;
                    if (mem.mem_rdata == OP_HLT) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else if (has_operand(mem.mem_rdata)) begin
                        r_state <= S_OPLO;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end

                S_OPLO: begin
                    r_pc       <= w_pc_inc;
                    r_mem_addr <= w_pc_inc;
                    if (r_opcode == OP_LDI) begin
                        r_acc   <= w_alu_res;
                        r_z     <= w_alu_z;
                        r_state <= S_FETCH;
                    end else begin
                        r_oplo  <= mem.mem_rdata;
                        r_state <= S_OPHI;
                    end
                end

                S_OPHI: begin
                    r_pc        <= w_pc_inc;
                    r_operand   <= w_operand;
                    r_mem_addr  <= w_operand;
                    r_mem_we    <= (r_opcode == OP_STA);
                    r_mem_wdata <= r_acc;
                    r_state     <= S_EXEC;
                end

                S_EXEC: begin
                    r_state    <= S_FETCH;
                    r_mem_addr <= r_pc;
                    case (r_opcode)
                        OP_LDA: begin
                            r_acc <= w_alu_res;
                            r_z   <= w_alu_z;
                        end
                        OP_ADD, OP_SUB, OP_MUL, OP_DEC: begin
                            r_acc <= w_alu_res;
                            r_z   <= w_alu_z;
                            r_c   <= w_alu_c;
                        end
                        OP_JMP: begin
                            r_pc       <= r_operand;
                            r_mem_addr <= r_operand;
                        end
                        OP_JZ: begin
                            if (r_z) begin
                                r_pc       <= r_operand;
                                r_mem_addr <= r_operand;
                            end
                        end
                        OP_JNZ: begin
                            if (!r_z) begin
                                r_pc       <= r_operand;
                                r_mem_addr <= r_operand;
                            end
                        end
                        default: ;
                    endcase
                end

                S_HALT: ;

                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Gating with rst keeps an STA caught by reset in EXEC from ever writing.
    assign mem.mem_we    = r_mem_we & rst;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign halted        = r_halted;
    assign acc_out       = r_acc;
    assign pc_out        = r_pc;

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: directed programs plus random programs, each checked per instruction
// against an instruction-level reference model with its own copy of memory.
module tb_cpu_core;

    localparam int unsigned AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          halted;
    logic [7:0]    acc_out;
    logic [AW-1:0] pc_out;

    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];

    int n_total = 0;
    int n_bad   = 0;
    int cycles  = 0;

    logic [15:0] m_pc;
    logic [7:0]  m_a;
    logic        m_z;
    logic        m_c;
    logic        m_halt;

    cpu_if #(.ADDR_W(AW)) bus ();

    assign bus.mem_rdata = mem[bus.mem_addr];

    cpu_core #(.ADDR_W(AW), .RESET_PC(16'h0000)) dut (
        .clk     (clk),
        .rst     (rst),
        .mem     (bus),
        .halted  (halted),
        .acc_out (acc_out),
        .pc_out  (pc_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory model: capture the write strobe mid-cycle, commit just after the rising edge.
    task automatic step(input int n);
        logic        cw;
        logic [15:0] ca;
        logic [7:0]  cd;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cw = bus.mem_we;
            ca = bus.mem_addr;
            cd = bus.mem_wdata;
            @(posedge clk);
            #1;
            if (cw) mem[ca] = cd;
            cycles++;
        end
    endtask

    task automatic put(input int a, input logic [7:0] b);
        mem[16'(a)]     = b;
        ref_mem[16'(a)] = b;
    endtask

    task automatic put_seq(input int base, input logic [7:0] q[$]);
        foreach (q[i]) put(base + i, q[i]);
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 65536; a++) put(a, 8'h00);
    endtask

    // Executes one whole instruction on the model; returns its cycle cost.
    task automatic ref_exec(output int cyc);
        logic [7:0]  op;
        logic [7:0]  m;
        logic [15:0] ea;
        int          t;
        op   = ref_mem[m_pc];
        m_pc = m_pc + 16'd1;
        cyc  = 2;
        if (op == 8'hFF) begin
            m_halt = 1'b1;
            cyc    = 1;
        end else if (op == 8'h01) begin
            m_a  = ref_mem[m_pc];
            m_pc = m_pc + 16'd1;
            m_z  = (m_a == 8'd0);
        end else if (op >= 8'h02 && op <= 8'h09) begin
            ea[7:0]  = ref_mem[m_pc];
            m_pc     = m_pc + 16'd1;
            ea[15:8] = ref_mem[m_pc];
            m_pc     = m_pc + 16'd1;
            m        = ref_mem[ea];
            cyc      = 4;
            case (op)
                8'h02: begin m_a = m; m_z = (m_a == 8'd0); end
                8'h03: ref_mem[ea] = m_a;
                8'h04: begin t = int'(m_a) + int'(m); m_c = (t > 255); m_a = 8'(t); m_z = (m_a == 8'd0); end
                8'h05: begin m_c = (m_a < m); m_a = m_a - m; m_z = (m_a == 8'd0); end
                8'h06: begin t = int'(m_a) * int'(m); m_c = (t > 255); m_a = 8'(t); m_z = (m_a == 8'd0); end
                8'h07: m_pc = ea;
                8'h08: if (m_z) m_pc = ea;
                default: if (!m_z) m_pc = ea;
            endcase
        end else if (op == 8'h0A) begin
            m_c = (m_a == 8'd0);
            m_a = m_a - 8'd1;
            m_z = (m_a == 8'd0);
        end
    endtask

    task automatic run_prog(input string name, input int max_instr, output int ncyc);
        int cyc;
        int diffs;
        m_pc = 16'h0000; m_a = 8'h00; m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0;
        ncyc = 0;
        rst  = 1'b0;
        step(2);
        chk({name, ":rst_pc"},   32'(pc_out), 32'h0);
        chk({name, ":rst_acc"},  32'(acc_out), 32'h0);
        chk({name, ":rst_halt"}, 32'(halted), 32'h0);
        chk({name, ":rst_we"},   32'(bus.mem_we), 32'h0);
        chk({name, ":rst_addr"}, 32'(bus.mem_addr), 32'h0);
        rst = 1'b1;
        for (int i = 0; i < max_instr && !m_halt; i++) begin
            ref_exec(cyc);
            step(cyc);
            ncyc += cyc;
            chk({name, ":pc"},   32'(pc_out), 32'(m_pc));
            chk({name, ":acc"},  32'(acc_out), 32'(m_a));
            chk({name, ":halt"}, 32'(halted), 32'(m_halt));
            chk({name, ":z"},    32'(dut.r_z), 32'(m_z));
            chk({name, ":c"},    32'(dut.r_c), 32'(m_c));
            chk({name, ":addr"}, 32'(bus.mem_addr), 32'(m_pc));
        end
        if (m_halt) begin
            step(3);
            chk({name, ":frz_pc"},  32'(pc_out), 32'(m_pc));
            chk({name, ":frz_acc"}, 32'(acc_out), 32'(m_a));
            chk({name, ":frz_hlt"}, 32'(halted), 32'h1);
            chk({name, ":frz_we"},  32'(bus.mem_we), 32'h0);
        end
        diffs = 0;
        for (int a = 0; a < 65536; a++) if (mem[a] !== ref_mem[a]) diffs++;
        chk({name, ":memdiff"}, 32'(diffs), 32'h0);
    endtask

    task automatic gen_random();
        int         pc;
        int         r;
        logic [7:0] imm;
        clear_mem();
        for (int a = 16'h0100; a < 16'h0110; a++) put(a, 8'($urandom_range(0, 255)));
        pc = 0;
        while (pc < 'h78) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                put(pc, 8'hFF); pc += 1;
            end else if (r < 10) begin
                put(pc, 8'h00); pc += 1;
            end else if (r < 22) begin
                imm = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom_range(0, 255));
                put(pc, 8'h01); put(pc + 1, imm); pc += 2;
            end else if (r < 60) begin
                put(pc, 8'($urandom_range(2, 6))); put(pc + 1, 8'($urandom_range(0, 15)));
                put(pc + 2, 8'h01); pc += 3;
            end else if (r < 74) begin
                put(pc, 8'($urandom_range(7, 9))); put(pc + 1, 8'($urandom_range(0, 'h7F)));
                put(pc + 2, 8'h00); pc += 3;
            end else if (r < 90) begin
                put(pc, 8'h0A); pc += 1;
            end else begin
                put(pc, 8'($urandom_range(11, 254))); pc += 1;
            end
        end
    endtask

    initial begin
        int         nc;
        logic [7:0] q[$];
        rst = 1'b0;

        // 5! via MUL/DEC/JNZ loop, result stored at 0x0100.
        clear_mem();
        q = '{8'h01, 8'h05, 8'h03, 8'h00, 8'h02, 8'h01, 8'h01, 8'h03, 8'h00, 8'h01,
              8'h02, 8'h00, 8'h01, 8'h06, 8'h00, 8'h02, 8'h03, 8'h00, 8'h01,
              8'h02, 8'h00, 8'h02, 8'h0A, 8'h03, 8'h00, 8'h02, 8'h09, 8'h0A, 8'h00, 8'hFF};
        put_seq(0, q);
        run_prog("fact", 300, nc);
        chk("fact_result", 32'(mem[16'h0100]), 32'h78);
        chk("fact_halted", 32'(halted), 32'h1);

        // Carry out of ADD, borrow out of SUB.
        clear_mem();
        q = '{8'h01, 8'hFF, 8'h03, 8'h00, 8'h02, 8'h04, 8'h00, 8'h02,
              8'h01, 8'h01, 8'h05, 8'h00, 8'h02, 8'hFF};
        put_seq(0, q);
        run_prog("carry", 20, nc);
        chk("carry_acc", 32'(acc_out), 32'h02);
        chk("carry_c",   32'(dut.r_c), 32'h1);
        chk("carry_z",   32'(dut.r_z), 32'h0);

        // JZ taken then not taken.
        clear_mem();
        q = '{8'h01, 8'h00, 8'h08, 8'h10, 8'h00};
        put_seq(0, q);
        q = '{8'h01, 8'h01, 8'h08, 8'h20, 8'h00, 8'hFF};
        put_seq('h10, q);
        run_prog("jz", 20, nc);
        chk("jz_pc",  32'(pc_out), 32'h16);
        chk("jz_cyc", 32'(nc), 32'd13);

        // Undefined opcode runs as a 2-cycle NOP.
        clear_mem();
        q = '{8'h55, 8'hFF};
        put_seq(0, q);
        run_prog("undef", 10, nc);
        chk("undef_cyc", 32'(nc), 32'd3);
        chk("undef_acc", 32'(acc_out), 32'h0);
        chk("undef_hlt", 32'(halted), 32'h1);

        // PC wrap: NOP at 0xFFFF lands on a HLT written at 0x0000.
        clear_mem();
        q = '{8'h07, 8'h20, 8'h00};
        put_seq(0, q);
        q = '{8'h01, 8'hFF, 8'h03, 8'h00, 8'h00, 8'h07, 8'hFF, 8'hFF};
        put_seq('h20, q);
        run_prog("wrap", 20, nc);
        chk("wrap_pc",  32'(pc_out), 32'h0001);
        chk("wrap_mem", 32'(mem[16'h0000]), 32'hFF);

        // Reset while STA sits in EXEC must suppress the write.
        clear_mem();
        q = '{8'h01, 8'hAA, 8'h03, 8'h00, 8'h03, 8'hFF};
        put_seq(0, q);
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        step(5);
        chk("sta_we",    32'(bus.mem_we), 32'h1);
        chk("sta_addr",  32'(bus.mem_addr), 32'h0300);
        chk("sta_wdata", 32'(bus.mem_wdata), 32'hAA);
        rst = 1'b0;
        step(1);
        chk("sta_nowr", 32'(mem[16'h0300]), 32'h00);
        chk("sta_pc",   32'(pc_out), 32'h0);
        chk("sta_acc",  32'(acc_out), 32'h0);
        chk("sta_we0",  32'(bus.mem_we), 32'h0);

        for (int s = 0; s < 8; s++) begin
            gen_random();
            run_prog($sformatf("rnd%0d", s), 150, nc);
        end

        chk("cycle_budget", 32'(cycles < 90000), 32'h1);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
